// File: rtl/load_store_unit_pkg.sv
// Shared constants for the load/store unit: access size codes, FSM state
// encodings and the alignment rule used when a request is accepted.
package load_store_unit_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_RESP  = 2'b11
  } lsu_state_e;

  // A request is rejected when its address does not sit on a boundary of its
  // own size, or when it uses the reserved size code.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lane[0];
      SZ_WORD: bad = |lane;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Byte-lane steering between the word-wide memory and the core:
// extraction plus sign/zero extension for loads, and lane merge for stores.
// Lanes are little-endian: byte k sits at bits [8k+7:8k], k = addr[1:0].
module lsu_lane_align
  import load_store_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rd_word_i,
  input  logic [DATA_W-1:0] old_word_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [1:0]        lane_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  output logic [DATA_W-1:0] ld_data_o,
  output logic [DATA_W-1:0] st_word_o
);

  function automatic logic [DATA_W-1:0] extend_byte(input logic signed [7:0] b, input logic uns);
    logic signed [DATA_W-1:0] s;
    s = b;
    return uns ? {{(DATA_W-8){1'b0}}, b} : s;
  endfunction

  function automatic logic [DATA_W-1:0] extend_half(input logic signed [15:0] h, input logic uns);
    logic signed [DATA_W-1:0] s;
    s = h;
    return uns ? {{(DATA_W-16){1'b0}}, h} : s;
  endfunction

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lane(s) out of the memory word and extend to a full word.
  always_comb begin
    byte_sel = rd_word_i[{lane_i, 3'b000} +: 8];
    half_sel = lane_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];
    case (size_i)
      SZ_BYTE: ld_data_o = extend_byte(byte_sel, unsigned_i);
      SZ_HALF: ld_data_o = extend_half(half_sel, unsigned_i);
      default: ld_data_o = rd_word_i;
    endcase
  end

  // Replace only the addressed lane(s) of the old word with right-justified store data.
  always_comb begin
    st_word_o = old_word_i;
    case (size_i)
      SZ_BYTE: st_word_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
      SZ_HALF: begin
        if (lane_i[1]) st_word_o[31:16] = wdata_i[15:0];
        else           st_word_o[15:0]  = wdata_i[15:0];
      end
      default: st_word_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit sitting directly upstream of DataMemory. Runs byte, half
// and word accesses against word-wide memory; sub-word stores are done as a
// read-modify-write. One request at a time, completion flagged by done.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              startin,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              is_store,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [DATA_W-1:0] MemWriteData,
  output logic              MemWrite,
  output logic              MemRead,
  input  logic [DATA_W-1:0] MemReadData
);

  lsu_state_e        state_q;
  logic              is_store_q;
  logic [1:0]        size_q;
  logic              unsigned_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] merge_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic [DATA_W-1:0] ld_ext;
  logic [DATA_W-1:0] st_merged;
  logic [ADDR_W-1:0] word_addr;

  lsu_lane_align #(
    .DATA_W(DATA_W)
  ) u_lane_align (
    .rd_word_i (MemReadData),
    .old_word_i(merge_q),
    .wdata_i   (wdata_q),
    .lane_i    (addr_q[1:0]),
    .size_i    (size_q),
    .unsigned_i(unsigned_q),
    .ld_data_o (ld_ext),
    .st_word_o (st_merged)
  );

  assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};

  // Request FSM: latch on accept, read and/or write memory, then a one-cycle response.
  always_ff @(posedge clk) begin
    if (startin) begin
      state_q    <= ST_IDLE;
      is_store_q <= 1'b0;
      size_q     <= SZ_BYTE;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      merge_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            is_store_q <= is_store;
            size_q     <= size;
            unsigned_q <= unsigned_ld;
            addr_q     <= addr;
            wdata_q    <= wdata;
            err_q      <= 1'b0;
            if (is_misaligned(size, addr[1:0])) begin
              // Rejected requests never touch memory.
              err_q   <= 1'b1;
              state_q <= ST_RESP;
            end else if (is_store && (size == SZ_WORD)) begin
              // Full-word stores need no merge, so skip the read.
              state_q <= ST_WRITE;
            end else begin
              state_q <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (is_store_q) begin
            merge_q <= MemReadData;
            state_q <= ST_WRITE;
          end else begin
            rdata_q <= ld_ext;
            state_q <= ST_RESP;
          end
        end
        ST_WRITE: state_q <= ST_RESP;
        ST_RESP:  state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  // Memory strobes follow the state; reset suppresses them so a write cannot land mid-reset.
  always_comb begin
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    MemAddress   = '0;
    MemWriteData = '0;
    case (state_q)
      ST_READ: begin
        MemRead    = ~startin;
        MemAddress = word_addr;
      end
      ST_WRITE: begin
        MemWrite     = ~startin;
        MemAddress   = word_addr;
        MemWriteData = st_merged;
      end
      default: ;
    endcase
  end

  assign req_ready = (state_q == ST_IDLE) && !startin;
  assign done      = (state_q == ST_RESP);
  assign rdata     = rdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a small word memory model.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam logic [31:0] PRELOAD = 32'h8899AABB;

  logic        clk;
  logic        startin;
  logic        req_valid;
  logic        req_ready;
  logic        is_store;
  logic [1:0]  size;
  logic        unsigned_ld;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        err;
  logic [31:0] MemAddress;
  logic [31:0] MemWriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] MemReadData;

  logic [31:0] mem [0:15];
  logic        load_mem;

  typedef struct packed {
    logic        chk;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;

  int n_cmp = 0;
  int n_mis = 0;

  int          obs_done, obs_nwr, obs_wrc, obs_nrd, obs_rdc;
  logic [31:0] obs_wrd, obs_rda;
  logic        obs_rdy;

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .startin(startin), .req_valid(req_valid), .req_ready(req_ready),
    .is_store(is_store), .size(size), .unsigned_ld(unsigned_ld), .addr(addr),
    .wdata(wdata), .rdata(rdata), .done(done), .err(err),
    .MemAddress(MemAddress), .MemWriteData(MemWriteData), .MemWrite(MemWrite),
    .MemRead(MemRead), .MemReadData(MemReadData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DataMemory model: combinational read, write on rising edge.
  assign MemReadData = MemRead ? mem[MemAddress[5:2]] : 32'h0;

  always @(posedge clk) begin
    if (load_mem) mem[2] <= PRELOAD;
    else if (MemWrite) mem[MemAddress[5:2]] <= MemWriteData;
  end

  // Scoreboard: each done pops the oldest expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        n_cmp++; n_mis++;
        $display("FAIL sb_unexpected_done: done=1 with no outstanding request");
      end else begin
        sb_e = sb_q.pop_front();
        n_cmp++;
        if (err !== sb_e.err) begin
          n_mis++;
          $display("FAIL sb_err: got %b expected %b", err, sb_e.err);
        end
        if (sb_e.chk) begin
          n_cmp++;
          if (rdata !== sb_e.rdata) begin
            n_mis++;
            $display("FAIL sb_rdata: got %h expected %h", rdata, sb_e.rdata);
          end
        end
      end
    end
  end

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] lane,
                                           input logic [1:0] sz, input logic uns);
    logic [31:0] sh;
    logic [31:0] r;
    sh = w >> {lane, 3'b000};
    case (sz)
      2'b00:   r = uns ? (sh & 32'hFF)   : (((sh & 32'hFF) ^ 32'h80) - 32'h80);
      2'b01:   r = uns ? (sh & 32'hFFFF) : (((sh & 32'hFFFF) ^ 32'h8000) - 32'h8000);
      default: r = w;
    endcase
    return r;
  endfunction

  // Drive one request, push its expectation, and record what the memory side did.
  task automatic do_req(input logic st, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic chk, input logic [31:0] erd, input logic eerr);
    exp_t e;
    @(negedge clk);
    obs_rdy = req_ready;
    is_store = st; size = sz; unsigned_ld = uns; addr = a; wdata = wd;
    req_valid = 1'b1;
    e.chk = chk; e.rdata = erd; e.err = eerr;
    sb_q.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
    obs_done = -1; obs_nwr = 0; obs_wrc = -1; obs_nrd = 0; obs_rdc = -1;
    obs_wrd = 32'h0; obs_rda = 32'h0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (MemWrite) begin obs_nwr++; obs_wrc = c; obs_wrd = MemWriteData; end
      if (MemRead)  begin obs_nrd++; obs_rdc = c; obs_rda = MemAddress; end
      if (done) begin obs_done = c; break; end
    end
  endtask

  task automatic test_reset();
    startin = 1'b1; load_mem = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b0) begin n_mis++; $display("FAIL rst_ready: got %b expected 0", req_ready); end
    n_cmp++; if (done !== 1'b0) begin n_mis++; $display("FAIL rst_done: got %b expected 0", done); end
    n_cmp++; if (err !== 1'b0) begin n_mis++; $display("FAIL rst_err: got %b expected 0", err); end
    n_cmp++; if (rdata !== 32'h0) begin n_mis++; $display("FAIL rst_rdata: got %h expected 0", rdata); end
    n_cmp++; if ((MemRead | MemWrite) !== 1'b0) begin n_mis++; $display("FAIL rst_mem_strobes: rd=%b wr=%b expected 0", MemRead, MemWrite); end
    @(posedge clk);
    #1 startin = 1'b0; load_mem = 1'b0;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_mis++; $display("FAIL rst_ready_after: got %b expected 1", req_ready); end
  endtask

  task automatic test_word_load();
    do_req(1'b0, SZ_WORD, 1'b0, 32'h8, 32'h0, 1'b1, PRELOAD, 1'b0);
    n_cmp++; if (obs_rdy !== 1'b1) begin n_mis++; $display("FAIL lw_ready: got %b expected 1", obs_rdy); end
    n_cmp++; if (obs_done != 2) begin n_mis++; $display("FAIL lw_latency: got %0d expected 2", obs_done); end
    n_cmp++; if (obs_nrd != 1 || obs_rdc != 1) begin n_mis++; $display("FAIL lw_read: count %0d cycle %0d expected 1/1", obs_nrd, obs_rdc); end
    n_cmp++; if (obs_rda !== 32'h8) begin n_mis++; $display("FAIL lw_addr: got %h expected 8", obs_rda); end
    n_cmp++; if (obs_nwr != 0) begin n_mis++; $display("FAIL lw_nowrite: got %0d writes expected 0", obs_nwr); end
  endtask

  task automatic test_subword_loads();
    logic [1:0] ln;
    logic [1:0] sz;
    logic       un;
    for (int k = 0; k < 12; k++) begin
      if (k < 8) begin ln = 2'(k >> 1); sz = SZ_BYTE; end
      else begin ln = (k < 10) ? 2'd0 : 2'd2; sz = SZ_HALF; end
      un = k[0];
      do_req(1'b0, sz, un, {28'h0, 2'b10, ln}, 32'h0, 1'b1, ref_load(PRELOAD, ln, sz, un), 1'b0);
      n_cmp++; if (obs_done != 2) begin n_mis++; $display("FAIL subld_latency[%0d]: got %0d expected 2", k, obs_done); end
    end
  endtask

  task automatic test_sub_store();
    do_req(1'b1, SZ_BYTE, 1'b0, 32'h9, 32'h123456CC, 1'b0, 32'h0, 1'b0);
    n_cmp++; if (obs_done != 3) begin n_mis++; $display("FAIL sb_latency: got %0d expected 3", obs_done); end
    n_cmp++; if (obs_nwr != 1 || obs_wrc != 2) begin n_mis++; $display("FAIL sb_write: count %0d cycle %0d expected 1/2", obs_nwr, obs_wrc); end
    n_cmp++; if (obs_wrd !== 32'h8899CCBB) begin n_mis++; $display("FAIL sb_wdata: got %h expected 8899ccbb", obs_wrd); end
    n_cmp++; if (obs_nrd != 1 || obs_rdc != 1) begin n_mis++; $display("FAIL sb_read: count %0d cycle %0d expected 1/1", obs_nrd, obs_rdc); end
    do_req(1'b0, SZ_WORD, 1'b0, 32'h8, 32'h0, 1'b1, 32'h8899CCBB, 1'b0);
    do_req(1'b1, SZ_HALF, 1'b0, 32'hE, 32'h0000A5A5, 1'b0, 32'h0, 1'b0);
    n_cmp++; if (obs_wrd[31:16] !== 16'hA5A5) begin n_mis++; $display("FAIL sh_hi_lane: got %h expected a5a5 in upper half", obs_wrd); end
  endtask

  task automatic test_misaligned();
    do_req(1'b0, SZ_HALF, 1'b0, 32'hB, 32'h0, 1'b0, 32'h0, 1'b1);
    n_cmp++; if (obs_done != 1) begin n_mis++; $display("FAIL mis_latency: got %0d expected 1", obs_done); end
    n_cmp++; if (obs_nrd != 0 || obs_nwr != 0) begin n_mis++; $display("FAIL mis_mem: reads %0d writes %0d expected 0/0", obs_nrd, obs_nwr); end
    do_req(1'b0, SZ_RSVD, 1'b0, 32'h8, 32'h0, 1'b0, 32'h0, 1'b1);
    n_cmp++; if (obs_done != 1) begin n_mis++; $display("FAIL rsvd_latency: got %0d expected 1", obs_done); end
    do_req(1'b1, SZ_WORD, 1'b0, 32'hA, 32'h01020304, 1'b0, 32'h0, 1'b1);
    n_cmp++; if (obs_nwr != 0) begin n_mis++; $display("FAIL mis_store_write: got %0d writes expected 0", obs_nwr); end
    do_req(1'b0, SZ_WORD, 1'b0, 32'h8, 32'h0, 1'b1, 32'h8899CCBB, 1'b0);
  endtask

  task automatic test_reset_mid_op();
    int wr_seen;
    int done_seen;
    wr_seen = 0; done_seen = 0;
    @(negedge clk);
    is_store = 1'b1; size = SZ_HALF; unsigned_ld = 1'b0; addr = 32'h8; wdata = 32'h00005555;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    startin = 1'b1;
    #1;
    if (MemWrite) wr_seen++;
    n_cmp++; if (MemRead !== 1'b0) begin n_mis++; $display("FAIL rmid_read_gated: got %b expected 0", MemRead); end
    n_cmp++; if (req_ready !== 1'b0) begin n_mis++; $display("FAIL rmid_ready_in_reset: got %b expected 0", req_ready); end
    @(posedge clk);
    #1 startin = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_cmp++; if (req_ready !== 1'b1) begin n_mis++; $display("FAIL rmid_ready_after: got %b expected 1", req_ready); end
      end
      if (MemWrite) wr_seen++;
      if (done) done_seen++;
    end
    n_cmp++; if (wr_seen != 0) begin n_mis++; $display("FAIL rmid_nowrite: got %0d writes expected 0", wr_seen); end
    n_cmp++; if (done_seen != 0) begin n_mis++; $display("FAIL rmid_nodone: got %0d done pulses expected 0", done_seen); end
    do_req(1'b0, SZ_WORD, 1'b0, 32'h8, 32'h0, 1'b1, 32'h8899CCBB, 1'b0);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic rdy [1:3];
    @(negedge clk);
    is_store = 1'b0; size = SZ_WORD; unsigned_ld = 1'b0; addr = 32'h8; wdata = 32'h0;
    req_valid = 1'b1;
    e.chk = 1'b1; e.rdata = 32'h8899CCBB; e.err = 1'b0; sb_q.push_back(e);
    @(posedge clk);
    #1;
    is_store = 1'b1; size = SZ_WORD; addr = 32'h8; wdata = 32'hDEADBEEF;
    e.chk = 1'b0; e.rdata = 32'h0; e.err = 1'b0; sb_q.push_back(e);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      rdy[c] = req_ready;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    n_cmp++; if (rdy[1] !== 1'b0 || rdy[2] !== 1'b0) begin n_mis++; $display("FAIL b2b_busy_ready: c1=%b c2=%b expected 0/0", rdy[1], rdy[2]); end
    n_cmp++; if (rdy[3] !== 1'b1) begin n_mis++; $display("FAIL b2b_idle_ready: got %b expected 1", rdy[3]); end
    @(negedge clk);
    n_cmp++; if (MemWrite !== 1'b1) begin n_mis++; $display("FAIL b2b_write_c4: got %b expected 1", MemWrite); end
    n_cmp++; if (MemWriteData !== 32'hDEADBEEF) begin n_mis++; $display("FAIL b2b_wdata: got %h expected deadbeef", MemWriteData); end
    n_cmp++; if (MemAddress !== 32'h8) begin n_mis++; $display("FAIL b2b_addr: got %h expected 8", MemAddress); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b1) begin n_mis++; $display("FAIL b2b_done_c5: got %b expected 1", done); end
    do_req(1'b0, SZ_WORD, 1'b0, 32'h8, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0);
    do_req(1'b0, SZ_HALF, 1'b0, 32'hA, 32'h0, 1'b1, 32'hFFFFDEAD, 1'b0);
  endtask

  initial begin
    startin = 1'b1; load_mem = 1'b1; req_valid = 1'b0; is_store = 1'b0;
    size = SZ_BYTE; unsigned_ld = 1'b0; addr = 32'h0; wdata = 32'h0;
    test_reset();
    test_word_load();
    test_subword_loads();
    test_sub_store();
    test_misaligned();
    test_reset_mid_op();
    test_back_to_back();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_mis++;
      $display("FAIL sb_drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the datapath (ALU address and rt data) and DataMemory. It is the stage directly upstream of DataMemory.
- Executes byte, halfword and word loads and stores against the word-wide DataMemory.
- Sub-word stores use a read-modify-write sequence.
- Loads are sign- or zero-extended before being returned to write-back.
- Stalls the core with a valid/ready handshake and signals completion with a one-cycle done pulse.

Parameters:
- ADDR_W, 32, width of byte address on both sides.
- DATA_W, 32, word width; fixed at 32 (four byte lanes).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- startin  input  1  synchronous active-high reset
- req_valid  input  1  core presents a memory operation
- req_ready  output  1  unit can accept a request (high only in IDLE)
- is_store  input  1  1 = store, 0 = load
- size  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as misaligned/error)
- unsigned_ld  input  1  zero-extend loads when 1, sign-extend when 0
- addr  input  32  byte address
- wdata  input  32  store data, right-justified
- rdata  output  32  extended load result, valid when done=1
- done  output  1  one-cycle completion pulse
- err  output  1  misaligned or reserved size; valid with done
- MemAddress  output  32  to DataMemory Address, always word-aligned (addr & ~3)
- MemWriteData  output  32  to DataMemory WriteData
- MemWrite  output  1  to DataMemory MemWrite
- MemRead  output  1  to DataMemory MemRead
- MemReadData  input  32  from DataMemory ReadData (combinational read)

Behaviour:
- DataMemory contract: combinational read while MemRead=1; write of MemWriteData at the rising clk edge while MemWrite=1.
- Little-endian lanes: byte k occupies bits [8k+7:8k], where k = addr[1:0].
- Accept rule: a request is accepted on a rising edge with req_valid & req_ready. On acceptance, is_store, size, unsigned_ld, addr and wdata are latched; inputs are ignored afterwards.
- Alignment: half requires addr[0]=0; word requires addr[1:0]=0.
- FSM states: IDLE, READ, WRITE, RESP.
  - IDLE -> RESP when the request is misaligned or size=11. err is set and no memory access occurs.
  - IDLE -> READ for any load, and for a byte or half store.
  - IDLE -> WRITE for a word store.
  - READ -> RESP for a load; the extended result is registered into the rdata register from MemReadData.
  - READ -> WRITE for a sub-word store; MemReadData is latched into the merge register.
  - WRITE -> RESP.
  - RESP -> IDLE.
- Latency counted from the acceptance edge = cycle 0:
  - misaligned: done in cycle 1
  - load: done in cycle 2
  - word store: done in cycle 2
  - sub-word store: done in cycle 3
- Memory drive per state (MemRead, MemWrite and MemAddress are combinational from state):
  - READ: MemRead=1.
  - WRITE: MemWrite=1 and MemWriteData = merged word. Only the addressed lane(s) are replaced by wdata[7:0] or wdata[15:0]. For a word store MemWriteData = wdata.
  - All other states: MemRead=0, MemWrite=0, MemAddress=0, MemWriteData=0.
- Exactly one MemWrite cycle per store, zero per load or error.
- done=1 only in RESP. rdata and err hold their value until the next RESP. err is cleared on every accept.
- Reset (startin=1 at an edge): state goes to IDLE; rdata=0, done=0, err=0, latched request cleared.
  - MemWrite and MemRead are gated by ~startin, so no write occurs in a reset cycle even mid-WRITE.
  - req_ready=0 while startin=1, and 1 in the first cycle after reset.
- req_valid held high while busy has no effect; the next request is accepted in the IDLE cycle following RESP.

Decomposition:
- Shared constants header: size codes (SZ_BYTE, SZ_HALF, SZ_WORD) and FSM state encodings. The core decoder also includes this header.
- One combinational sub-module, lsu_lane_align:
  - extract/extend for loads (lane select plus sign/zero extension)
  - lane merge for stores (old word, wdata, addr[1:0], size -> new word)
- FSM and registers live in load_store_unit.

Test Plan:
- Preload word 0x8 = 0x8899AABB. LW addr=0x8 -> MemRead in cycle 1 with MemAddress=0x8; done in cycle 2; rdata=0x8899AABB; err=0.
- LB addr=0xA -> rdata=0xFFFFFF99. LBU addr=0xA -> rdata=0x00000099. LHU addr=0xA -> rdata=0x00008899.
- SB addr=0x9 wdata=0x123456CC -> one MemWrite pulse in cycle 2 with MemWriteData=0x8899CCBB; done in cycle 3; a subsequent LW 0x8 returns 0x8899CCBB.
- LH addr=0xB (misaligned) -> done and err=1 in cycle 1; MemRead=MemWrite=0 throughout. A following LW 0x8 has err=0.
- SH addr=0x8 with startin pulsed during READ -> no MemWrite ever asserted; memory unchanged; req_ready=1 in the cycle after reset.
- Back-to-back: req_valid held high for LW 0x8 then SW 0x8 wdata=0xDEADBEEF -> req_ready low from cycles 1-2; second request accepted at the edge ending IDLE cycle 3; MemWrite in cycle 4 with data 0xDEADBEEF.
